// File: rtl/bcd_conv_arbiter_if.sv
// -----------------------------------------------------------------------------
// bcd_conv_arbiter_if
// Client-side bus of the shared binary-to-BCD converter.
//
// Handshake: a client raises req[i] and holds data_in[8*i+7:8*i] steady until
// it sees grant[i]. grant[i] is a one-cycle pulse that follows the clock edge
// on which the converter captured that client's value; the value may change
// afterwards. A client that keeps req[i] high after its grant is treated as a
// fresh request. Each captured job produces exactly one bcd_valid pulse,
// qualifying bcd_out/bcd_id, unless reset aborts it.
//
// Signals:
//   req       [NREQ-1:0]   per-client request, level
//   data_in   [8*NREQ-1:0] packed client values, client i on [8*i+7:8*i]
//   grant     [NREQ-1:0]   one-hot capture acknowledge
//   busy                   conversion in progress
//   bcd_out   [11:0]       hundreds/tens/ones digits
//   bcd_id    [IDW-1:0]    client index of bcd_out
//   bcd_valid              one-cycle result strobe
//   state_dbg [1:0]        converter FSM state (0 IDLE, 1 SHIFT, 2 DONE)
// -----------------------------------------------------------------------------
interface bcd_conv_arbiter_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] data_in;
    logic [NREQ-1:0]   grant;
    logic              busy;
    logic [11:0]       bcd_out;
    logic [IDW-1:0]    bcd_id;
    logic              bcd_valid;
    logic [1:0]        state_dbg;

    modport master (
        output req, data_in,
        input  grant, busy, bcd_out, bcd_id, bcd_valid, state_dbg
    );

    modport slave (
        input  req, data_in,
        output grant, busy, bcd_out, bcd_id, bcd_valid, state_dbg
    );
endinterface

// File: rtl/bcd_conv_arbiter.sv
// -----------------------------------------------------------------------------
// bcd_conv_arbiter
// Round-robin arbiter in front of one sequential double-dabble converter.
// One 8-bit client value is captured in IDLE, converted over 8 SHIFT cycles,
// and the 3-digit BCD result is presented for one DONE cycle with bcd_valid.
//
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high reset
//   bus    bcd_conv_arbiter_if.slave (req/data_in in; grant, busy, bcd_out,
//          bcd_id, bcd_valid, state_dbg out)
//
// Parameters: NREQ clients (2..8), IDW index width with 2**IDW >= NREQ.
// -----------------------------------------------------------------------------
module bcd_conv_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                clk,
    input  logic                reset,
    bcd_conv_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;

    logic [IDW-1:0]    r_ptr;
    logic [IDW-1:0]    r_id;
    logic [2:0]        r_cnt;
    logic [19:0]       r_shift;
    logic [NREQ-1:0]   r_grant;
    logic              r_busy;
    logic [11:0]       r_bcd_out;
    logic [IDW-1:0]    r_bcd_id;
    logic              r_bcd_valid;

    logic [7:0]        w_req_pad;
    logic [63:0]       w_data_pad;
    logic [4:0]        w_idx;
    logic [2:0]        w_sel;
    logic              w_found;
    logic [7:0]        w_sel_data;
    logic [19:0]       w_adj;
    logic [19:0]       w_shift_next;

    // Pad to the maximum client count so the selects below always use a
    // fixed 3-bit index regardless of NREQ.
    assign w_req_pad  = 8'(bus.req);
    assign w_data_pad = 64'(bus.data_in);
    assign w_sel_data = w_data_pad[{w_sel, 3'b000} +: 8];

    // Round-robin pick: first asserted req scanning upward from ptr+1 with
    // wrap, so the most recently served client is considered last.
    always_comb begin
        w_idx   = '0;
        w_sel   = '0;
        w_found = 1'b0;
        for (int k = 1; k <= NREQ; k++) begin
            w_idx = 5'(r_ptr) + 5'(k);
            if (w_idx >= 5'(NREQ)) begin
                w_idx = w_idx - 5'(NREQ);
            end
            if (!w_found && w_req_pad[w_idx[2:0]]) begin
                w_found = 1'b1;
                w_sel   = w_idx[2:0];
            end
        end
    end

    function automatic logic [3:0] dabble(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // One double-dabble iteration: adjust each BCD digit independently
    // (no carry between fields), then shift the whole register left.
    assign w_adj        = {dabble(r_shift[19:16]), dabble(r_shift[15:12]),
                           dabble(r_shift[11:8]), r_shift[7:0]};
    assign w_shift_next = {w_adj[18:0], 1'b0};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_found) w_state_next = SHIFT;
            SHIFT:   if (r_cnt == 3'd7) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ptr       <= IDW'(NREQ - 1);
            r_id        <= '0;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_grant     <= '0;
            r_busy      <= 1'b0;
            r_bcd_out   <= '0;
            r_bcd_id    <= '0;
            r_bcd_valid <= 1'b0;
        end else begin
            r_grant     <= '0;
            r_bcd_valid <= 1'b0;
            r_busy      <= (w_state_next != IDLE);
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_shift <= {12'b0, w_sel_data};
                        r_ptr   <= IDW'(w_sel);
                        r_id    <= IDW'(w_sel);
                        r_cnt   <= '0;
                        r_grant <= {{(NREQ-1){1'b0}}, 1'b1} << w_sel;
                    end
                end
                SHIFT: begin
                    r_shift <= w_shift_next;
                    r_cnt   <= r_cnt + 3'd1;
                    // The result is taken from the post-iteration value on the
                    // final edge, so it is already stable when DONE starts.
                    if (r_cnt == 3'd7) begin
                        r_bcd_out   <= w_shift_next[19:8];
                        r_bcd_id    <= r_id;
                        r_bcd_valid <= 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.grant     = r_grant;
    assign bus.busy      = r_busy;
    assign bus.bcd_out   = r_bcd_out;
    assign bus.bcd_id    = r_bcd_id;
    assign bus.bcd_valid = r_bcd_valid;
    assign bus.state_dbg = r_state;

endmodule

// File: tb/tb_bcd_conv_arbiter.sv
module tb_bcd_conv_arbiter;

    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;

    always #5 clk = ~clk;

    bcd_conv_arbiter_if #(.NREQ(NREQ), .IDW(IDW)) bus ();

    bcd_conv_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [3:0]  req;
        logic [31:0] data;
        logic [3:0]  exp_grant;
        logic [11:0] exp_bcd;
        logic [1:0]  exp_id;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference: plain decimal digit extraction.
    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    function automatic logic [31:0] put(input int client, input int v);
        return 32'(v & 255) << (8 * client);
    endfunction

    task automatic do_reset();
        @(negedge clk);
        bus.req     = '0;
        bus.data_in = '0;
        reset       = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    // Drives one request pattern, drops all requests once a grant is seen,
    // then checks grant, busy duration, result latency, result and strobe width.
    task automatic run_job(input logic [3:0] req, input logic [31:0] data,
                           input logic [3:0] exp_grant, input logic [11:0] exp_bcd,
                           input logic [1:0] exp_id, input string tag);
        int  n;
        int  lat;
        int  busy_cnt;
        bit  seen;
        logic [3:0] g;
        @(negedge clk);
        bus.req     = req;
        bus.data_in = data;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 30) begin
            @(negedge clk);
            n++;
            if (bus.grant != '0) seen = 1'b1;
        end
        g = bus.grant;
        check({tag, "_grant"}, 32'(g), 32'(exp_grant));
        bus.req = '0;
        busy_cnt = bus.busy ? 1 : 0;
        lat = 0;
        seen = 1'b0;
        while (!seen && lat < 30) begin
            @(negedge clk);
            lat++;
            if (bus.busy) busy_cnt++;
            if (bus.bcd_valid) seen = 1'b1;
        end
        check({tag, "_valid_latency"}, 32'(lat), 32'd8);
        check({tag, "_bcd_out"}, 32'(bus.bcd_out), 32'(exp_bcd));
        check({tag, "_bcd_id"}, 32'(bus.bcd_id), 32'(exp_id));
        @(negedge clk);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd9);
        check({tag, "_valid_one_cycle"}, {31'b0, bus.bcd_valid | bus.busy}, 32'd0);
    endtask

    initial begin : main
        int   n;
        int   grants;
        int   last_valid;
        bit   seen;
        logic [31:0] d;

        vecs[0] = '{4'b0001, put(0, 255), 4'b0001, 12'h255, 2'd0};
        vecs[1] = '{4'b0100, put(2, 0),   4'b0100, 12'h000, 2'd2};
        vecs[2] = '{4'b0100, put(2, 9),   4'b0100, 12'h009, 2'd2};
        vecs[3] = '{4'b0100, put(2, 10),  4'b0100, 12'h010, 2'd2};
        vecs[4] = '{4'b0100, put(2, 99),  4'b0100, 12'h099, 2'd2};
        vecs[5] = '{4'b0100, put(2, 100), 4'b0100, 12'h100, 2'd2};
        vecs[6] = '{4'b0100, put(2, 199), 4'b0100, 12'h199, 2'd2};
        vecs[7] = '{4'b0010, put(1, 42),  4'b0010, 12'h042, 2'd1};
        // Last served was client 1: scan 2,3,... so client 3 beats client 0.
        vecs[8] = '{4'b1001, put(0, 5) | put(3, 250), 4'b1000, 12'h250, 2'd3};
        vecs[9] = '{4'b0001, put(0, 5),   4'b0001, 12'h005, 2'd0};

        bus.req     = '0;
        bus.data_in = '0;
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_grant", 32'(bus.grant), 32'd0);
        check("reset_busy", {31'b0, bus.busy}, 32'd0);
        check("reset_bcd_out", 32'(bus.bcd_out), 32'd0);
        check("reset_bcd_id", 32'(bus.bcd_id), 32'd0);
        check("reset_bcd_valid", {31'b0, bus.bcd_valid}, 32'd0);
        check("reset_state", 32'(bus.state_dbg), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_job(vecs[i].req, vecs[i].data, vecs[i].exp_grant,
                    vecs[i].exp_bcd, vecs[i].exp_id, $sformatf("vec%0d", i));
        end

        for (int v = 0; v < 256; v++) begin
            int c;
            c = v % 4;
            run_job(4'(1 << c), put(c, v), 4'(1 << c), to_bcd(v), 2'(c),
                    $sformatf("sweep%0d", v));
        end

        // Contention: all clients held high from a fresh reset.
        do_reset();
        @(negedge clk);
        bus.req     = 4'b1111;
        bus.data_in = put(0, 11) | put(1, 22) | put(2, 33) | put(3, 44);
        last_valid  = 0;
        for (int k = 0; k < 5; k++) begin
            n = 0;
            seen = 1'b0;
            while (!seen && n < 30) begin
                @(negedge clk);
                n++;
                if (bus.grant != '0) seen = 1'b1;
            end
            check($sformatf("cont%0d_grant", k), 32'(bus.grant), 32'(1 << (k % 4)));
            n = 0;
            seen = 1'b0;
            while (!seen && n < 30) begin
                @(negedge clk);
                n++;
                if (bus.bcd_valid) seen = 1'b1;
            end
            check($sformatf("cont%0d_bcd_out", k), 32'(bus.bcd_out),
                  32'(to_bcd(11 * ((k % 4) + 1))));
            check($sformatf("cont%0d_bcd_id", k), 32'(bus.bcd_id), 32'(k % 4));
            if (k > 0) check($sformatf("cont%0d_spacing", k), 32'(cyc - last_valid), 32'd10);
            last_valid = cyc;
        end
        bus.req = '0;
        repeat (12) @(negedge clk);

        // Dropped request and mid-conversion data change (ptr now 0).
        @(negedge clk);
        bus.req     = 4'b0001;
        bus.data_in = put(0, 77);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 30) begin
            @(negedge clk);
            n++;
            if (bus.grant != '0) seen = 1'b1;
        end
        check("drop_grant0", 32'(bus.grant), 32'b0001);
        bus.req     = 4'b0100;
        bus.data_in = put(0, 200) | put(2, 33);
        repeat (2) @(negedge clk);
        bus.req = '0;
        grants = 0;
        n = 0;
        seen = 1'b0;
        while (!seen && n < 30) begin
            @(negedge clk);
            n++;
            if (bus.grant != '0) grants++;
            if (bus.bcd_valid) seen = 1'b1;
        end
        check("captured_bcd_out", 32'(bus.bcd_out), 32'h077);
        check("captured_bcd_id", 32'(bus.bcd_id), 32'd0);
        repeat (15) begin
            @(negedge clk);
            if (bus.grant != '0) grants++;
        end
        check("dropped_req_grants", 32'(grants), 32'd0);

        // Reset during SHIFT iteration 4.
        @(negedge clk);
        bus.req     = 4'b0001;
        bus.data_in = put(0, 200);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 30) begin
            @(negedge clk);
            n++;
            if (bus.grant != '0) seen = 1'b1;
        end
        bus.req = '0;
        repeat (4) @(negedge clk);
        check("pre_abort_state", 32'(bus.state_dbg), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("abort_grant", 32'(bus.grant), 32'd0);
        check("abort_busy", {31'b0, bus.busy}, 32'd0);
        check("abort_bcd_out", 32'(bus.bcd_out), 32'd0);
        check("abort_bcd_id", 32'(bus.bcd_id), 32'd0);
        check("abort_bcd_valid", {31'b0, bus.bcd_valid}, 32'd0);
        check("abort_state", 32'(bus.state_dbg), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        n = 0;
        repeat (12) begin
            @(negedge clk);
            if (bus.bcd_valid) n++;
        end
        check("abort_no_valid", 32'(n), 32'd0);
        d = put(0, 7) | put(1, 8);
        run_job(4'b0011, d, 4'b0001, 12'h007, 2'd0, "rr_after_reset");
        run_job(4'b0010, put(1, 128), 4'b0010, 12'h128, 2'd1, "reset_recover");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
